// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 pipeline: ALU opcode encoding and
// architectural constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int XLEN    = 64;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/wide_adder.sv
// Plain modulo-2^WIDTH adder; the carry out is intentionally dropped.
module wide_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: ALU, PC+4 incrementer and branch-target adder,
// all captured in a single output register (1-cycle latency).
module alu_exec_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic             branch,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic             take_branch
);

  function automatic logic signed [WIDTH-1:0] alu_eval(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input alu_op_e                 op
  );
    logic signed [WIDTH-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a + ~b + WIDTH'(1);
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic signed [WIDTH-1:0] opa_p0;
  logic signed [WIDTH-1:0] opb_p0;
  logic signed [WIDTH-1:0] alu_res_p0;
  logic                    zero_p0;
  logic                    vld_p0;
  logic [WIDTH-1:0]        step_p0;
  logic [WIDTH-1:0]        br_off_p0;
  logic [WIDTH-1:0]        pc_plus4_p0;
  logic [WIDTH-1:0]        br_tgt_p0;

  // Stage p0: combinational execute
  assign vld_p0     = in_valid;
  assign opa_p0     = rs1_data;
  assign opb_p0     = alu_src ? imm : rs2_data;
  assign alu_res_p0 = alu_eval(opa_p0, opb_p0, alu_op_e'(alu_op));
  assign zero_p0    = (alu_res_p0 == '0);
  assign step_p0    = WIDTH'(PC_STEP);
  // Offset is a logical shift by one: imm's MSB falls off the top.
  assign br_off_p0  = {imm[WIDTH-2:0], 1'b0};

  wide_adder #(.WIDTH(WIDTH)) u_pc_inc (
    .a   (pc),
    .b   (step_p0),
    .sum (pc_plus4_p0)
  );

  wide_adder #(.WIDTH(WIDTH)) u_br_tgt (
    .a   (pc),
    .b   (br_off_p0),
    .sum (br_tgt_p0)
  );

  // Stage p1: EX/MEM-facing output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
      take_branch   <= 1'b0;
    end else begin
      out_valid     <= vld_p0;
      alu_result    <= alu_res_p0;
      zero          <= zero_p0;
      pc_plus4      <= pc_plus4_p0;
      branch_target <= br_tgt_p0;
      take_branch   <= branch & zero_p0 & vld_p0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: table of hand-computed
// results plus reset sequences.
module tb_alu_exec_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] rs1_data, rs2_data, imm, pc;
  logic         alu_src, branch;
  logic [1:0]   alu_op;
  logic         out_valid, zero, take_branch;
  logic [W-1:0] alu_result, pc_plus4, branch_target;

  int n_pass  = 0;
  int n_total = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm           (imm),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .branch        (branch),
    .pc            (pc),
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .take_branch   (take_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         vld;
    logic [W-1:0] rs1, rs2, imm, pc;
    logic         src;
    logic [1:0]   op;
    logic         br;
    logic         chk_data;
    logic         e_vld;
    logic [W-1:0] e_res;
    logic         e_zero;
    logic [W-1:0] e_pc4, e_bt;
    logic         e_tb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.vld;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    imm      = v.imm;
    pc       = v.pc;
    alu_src  = v.src;
    alu_op   = v.op;
    branch   = v.br;
  endtask

  task automatic drive_random();
    in_valid = 1'b1;
    rs1_data = {$urandom, $urandom};
    rs2_data = rs1_data;
    imm      = {$urandom, $urandom};
    pc       = {$urandom, $urandom};
    alu_src  = 1'b0;
    alu_op   = 2'b01;
    branch   = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_valid"},     W'(out_valid),   '0);
    check({tag, ".alu_result"},    alu_result,      '0);
    check({tag, ".zero"},          W'(zero),        '0);
    check({tag, ".pc_plus4"},      pc_plus4,        '0);
    check({tag, ".branch_target"}, branch_target,   '0);
    check({tag, ".take_branch"},   W'(take_branch), '0);
  endtask

  function automatic vec_t mk(
    input string name, input logic vld, input logic [W-1:0] rs1, rs2, im,
    input logic src, input logic [1:0] op, input logic br, input logic [W-1:0] p,
    input logic chk, input logic e_vld, input logic [W-1:0] e_res, input logic e_zero,
    input logic [W-1:0] e_pc4, e_bt, input logic e_tb);
    vec_t v;
    v.name = name; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.imm = im;
    v.src = src; v.op = op; v.br = br; v.pc = p; v.chk_data = chk;
    v.e_vld = e_vld; v.e_res = e_res; v.e_zero = e_zero;
    v.e_pc4 = e_pc4; v.e_bt = e_bt; v.e_tb = e_tb;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            name        vld rs1            rs2      imm              src op    br pc                   chk evld res                  z  pc4      bt                   tb
    vecs.push_back(mk("add_imm", 1, 64'd5,       64'd0,   64'd3,           1, 2'b00, 0, 64'h0,               1,  1, 64'd8,               0, 64'h4,   64'h6,               0));
    vecs.push_back(mk("sub_beq", 1, 64'h1234,    64'h1234,64'h8,           0, 2'b01, 1, 64'h100,             1,  1, 64'h0,               1, 64'h104, 64'h110,             1));
    vecs.push_back(mk("and",     1, 64'hF0F0,    64'h0FF0,64'h0,           0, 2'b10, 0, 64'h200,             1,  1, 64'h00F0,            0, 64'h204, 64'h200,             0));
    vecs.push_back(mk("or",      1, 64'hF0F0,    64'h0FF0,64'h0,           0, 2'b11, 0, 64'h200,             1,  1, 64'hFFF0,            0, 64'h204, 64'h200,             0));
    vecs.push_back(mk("wrap_a",  1, 64'd0,       64'd1,   -64'sd4,         0, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, '1,              0, 64'h0,   64'hFFFF_FFFF_FFFF_FFF4, 0));
    vecs.push_back(mk("wrap_b",  1, 64'd0,       64'd0,   -64'sd4,         1, 2'b00, 0, 64'h10,              1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h14, 64'h8,           0));
    vecs.push_back(mk("and_beq", 1, 64'hF0,      64'h0F,  64'h0,           0, 2'b10, 1, 64'h0,               1,  1, 64'h0,               1, 64'h4,   64'h0,               1));
    vecs.push_back(mk("sub_bne", 1, 64'd10,      64'd3,   64'h4,           0, 2'b01, 1, 64'h20,              1,  1, 64'd7,               0, 64'h24,  64'h28,              0));
    vecs.push_back(mk("bub_1",   1, 64'd7,       64'd7,   64'h2,           0, 2'b01, 1, 64'h40,              1,  1, 64'h0,               1, 64'h44,  64'h44,              1));
    vecs.push_back(mk("bub_0",   0, 64'd7,       64'd7,   64'h2,           0, 2'b01, 1, 64'h40,              0,  0, 64'h0,               0, 64'h0,   64'h0,               0));
    vecs.push_back(mk("bub_2",   1, 64'd7,       64'd7,   64'h2,           0, 2'b01, 1, 64'h40,              1,  1, 64'h0,               1, 64'h44,  64'h44,              1));

    // Reset held across two edges with live-looking inputs
    rst = 1'b0;
    drive_random();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");

    @(negedge clk);
    rst = 1'b1;

    // Table: drive on falling edge, sample 1 ns after the rising edge
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".out_valid"},   W'(out_valid),   W'(vecs[i].e_vld));
      check({vecs[i].name, ".take_branch"}, W'(take_branch), W'(vecs[i].e_tb));
      if (vecs[i].chk_data) begin
        check({vecs[i].name, ".alu_result"},    alu_result,    vecs[i].e_res);
        check({vecs[i].name, ".zero"},          W'(zero),      W'(vecs[i].e_zero));
        check({vecs[i].name, ".pc_plus4"},      pc_plus4,      vecs[i].e_pc4);
        check({vecs[i].name, ".branch_target"}, branch_target, vecs[i].e_bt);
      end
      @(negedge clk);
    end

    // Asynchronous reset between edges, with an in-flight result
    drive(vecs[1]);
    @(posedge clk);
    #1;
    check("pre_async.take_branch", W'(take_branch), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("async_hold");
    @(negedge clk);
    rst = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check("post_rst.out_valid",  W'(out_valid), 64'd1);
    check("post_rst.alu_result", alu_result,    64'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
